header_stripper: RTL

- Receive side of the constant-header stream protocol: removes a fixed HEADER_SIZE-bit header from the front of each packet and forwards only the payload.
- Captures the header into a register for downstream inspection.
- Sits between the link/stream input and the AES datapath consumer.
- Uses the same valid/ready/sop/eop/empty streaming interface on both sides.

---
 rtl/header_stripper_if.sv | 16 +
 rtl/header_stripper.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/header_stripper_if.sv
// Valid/ready/sop/eop/empty stream bundle used on both sides of header_stripper.
interface header_stripper_if #(
    parameter int DATA_WIDTH = 128
);
    localparam int EMPTY_W = (DATA_WIDTH > 8) ? $clog2(DATA_WIDTH / 8) : 1;

    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;
    logic                  sop;
    logic                  eop;
    logic [EMPTY_W-1:0]    empty;

    modport master (output data, valid, sop, eop, empty, input ready);
    modport slave  (input data, valid, sop, eop, empty, output ready);
endinterface

// File: rtl/header_stripper.sv
// Strips a fixed HEADER_SIZE-bit header off each packet, latches it, forwards the payload.
// Optional HEADER_STRIPPER_CHECK_EN: compare against expected_header and drop mismatching packets.
module header_stripper #(
    parameter int DATA_WIDTH  = 128,
    parameter int HEADER_SIZE = 256
) (
    input  logic                   clk,
    input  logic                   rst_n,
    header_stripper_if.slave       data_in,
    header_stripper_if.master      data_out,
    output logic [HEADER_SIZE-1:0] header_out,
    output logic                   header_valid,
    output logic                   runt_err
`ifdef HEADER_STRIPPER_CHECK_EN
    ,
    input  logic [HEADER_SIZE-1:0] expected_header,
    output logic                   mismatch_err
`endif
);
    localparam int N    = HEADER_SIZE / DATA_WIDTH;
    localparam int CW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

`ifdef HEADER_STRIPPER_CHECK_EN
    typedef enum logic [1:0] {HDR_ST, DATA_ST, DROP_ST} state_t;
`else
    typedef enum logic [1:0] {HDR_ST, DATA_ST} state_t;
`endif

    state_t                 state, state_nxt;
    logic [CW-1:0]          hdr_cntr, hdr_cntr_nxt, slot;
    logic                   first_data, first_data_nxt;
    logic [HEADER_SIZE-1:0] shadow, assembled;
    logic                   hdr_wr, hdr_load, hv_nxt, runt_nxt, hdr_ok;
`ifdef HEADER_STRIPPER_CHECK_EN
    logic                   mm_nxt;
`endif

    // sop always restarts capture at slot 0, even mid-header
    assign slot = data_in.sop ? '0 : hdr_cntr;

    always_comb begin
        assembled                  = shadow;
        assembled[DATA_WIDTH-1:0]  = data_in.data;
    end

`ifdef HEADER_STRIPPER_CHECK_EN
    assign hdr_ok = (assembled == expected_header);
`else
    assign hdr_ok = 1'b1;
`endif

    always_comb begin
        data_in.ready  = 1'b0;
        data_out.valid = 1'b0;
        data_out.data  = data_in.data;
        data_out.sop   = 1'b0;
        data_out.eop   = 1'b0;
        data_out.empty = '0;
        state_nxt      = state;
        hdr_cntr_nxt   = hdr_cntr;
        first_data_nxt = first_data;
        hdr_wr         = 1'b0;
        hdr_load       = 1'b0;
        hv_nxt         = 1'b0;
        runt_nxt       = 1'b0;
`ifdef HEADER_STRIPPER_CHECK_EN
        mm_nxt         = 1'b0;
`endif
        case (state)
            HDR_ST: begin
                data_in.ready = 1'b1;
                // beats with hdr_cntr==0 and no sop are strays (e.g. tail after reset)
                if (data_in.valid && (data_in.sop || hdr_cntr != '0)) begin
                    hdr_wr = 1'b1;
                    if (slot == LAST) begin
                        hdr_load     = 1'b1;
                        hdr_cntr_nxt = '0;
                        if (hdr_ok) begin
                            hv_nxt = 1'b1;
                            if (!data_in.eop) state_nxt = DATA_ST;
                        end
`ifdef HEADER_STRIPPER_CHECK_EN
                        else begin
                            mm_nxt = 1'b1;
                            if (!data_in.eop) state_nxt = DROP_ST;
                        end
`endif
                    end else if (data_in.eop) begin
                        runt_nxt     = 1'b1;
                        hdr_cntr_nxt = '0;
                    end else begin
                        hdr_cntr_nxt = slot + 1'b1;
                    end
                end
            end
            DATA_ST: begin
                data_in.ready  = data_out.ready;
                data_out.valid = data_in.valid;
                data_out.sop   = first_data;
                data_out.eop   = data_in.eop;
                data_out.empty = data_in.eop ? data_in.empty : '0;
                if (data_in.valid && data_out.ready) begin
                    first_data_nxt = 1'b0;
                    if (data_in.eop) begin
                        state_nxt      = HDR_ST;
                        first_data_nxt = 1'b1;
                    end
                end
            end
`ifdef HEADER_STRIPPER_CHECK_EN
            DROP_ST: begin
                data_in.ready = 1'b1;
                if (data_in.valid && data_in.eop) state_nxt = HDR_ST;
            end
`endif
            default: state_nxt = HDR_ST;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= HDR_ST;
            hdr_cntr     <= '0;
            first_data   <= 1'b1;
            shadow       <= '0;
            header_out   <= '0;
            header_valid <= 1'b0;
            runt_err     <= 1'b0;
        end else begin
            state        <= state_nxt;
            hdr_cntr     <= hdr_cntr_nxt;
            first_data   <= first_data_nxt;
            header_valid <= hv_nxt;
            runt_err     <= runt_nxt;
            if (hdr_load) header_out <= assembled;
            for (int k = 0; k < N; k++) begin
                if (hdr_wr && slot == CW'(k))
                    shadow[HEADER_SIZE-1-DATA_WIDTH*k -: DATA_WIDTH] <= data_in.data;
            end
        end
    end

`ifdef HEADER_STRIPPER_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mismatch_err <= 1'b0;
        else        mismatch_err <= mm_nxt;
    end
`endif
endmodule
